addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Shared-resource arbiter and sequencer for the 32-bit ripple-carry add/subtract datapath. It accepts add/subtract requests from up to N_REQ independent requesters and grants one per cycle in round-robin order. It drives the single shared carry-chain adder and returns a registered result, tagged with the requester ID, through a one-entry output slot with valid/ready handshake. It sits between ALU clients (address generation, loop counters, the integer ALU front end) and the one physical adder instance.

## Interface

- N_REQ, default 4: number of requesters; 2 to 8.
- W, default 32: operand and result width.
- IDW, default 2: width of the requester ID; equals clog2(N_REQ), minimum 1.

- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_a  in  N_REQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  N_REQ*W  operand B; same packing as req_a.
- req_sub  in  N_REQ  1 = compute A − B; 0 = compute A + B.
- rsp_valid  out  1  result slot occupied.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_result  out  W  sum or difference, modulo 2^W.
- rsp_cout  out  1  carry out of bit W−1. For subtraction, 1 means no borrow.
- rsp_ovf  out  1  signed two's-complement overflow.

## Operation

- Datapath: result = A + (sub ? ~B : B) + sub. This uses one shared adder with carry-in equal to sub, and is evaluated on the granted requester's operands only.
- cout is the carry out of the MSB stage, not the carry into it.
- ovf = (A[W−1] == B'[W−1]) && (result[W−1] != A[W−1]), where B' is the post-inversion operand.
- States:
  - EMPTY: rsp_valid = 0.
  - FULL: rsp_valid = 1.
- can_accept = EMPTY || (FULL && rsp_ready).
- Arbitration: round-robin.
  - Priority starts at (last_grant + 1) mod N_REQ and searches upward with wrap-around.
  - grant is one-hot among asserted req_valid.
  - req_ready[i] = grant[i] && can_accept.
  - req_ready is combinational from req_valid, state and rsp_ready. It never depends on the requester's own req_ready.
- Accept (req_valid[i] && req_ready[i]):
  - The result, cout, ovf and ID are registered into the slot.
  - State becomes FULL.
  - last_grant ← i.
- FULL with rsp_ready and no accept in the same cycle: the slot drains and state becomes EMPTY.
- FULL with rsp_ready and an accept in the same cycle: the slot is overwritten with the new result and stays FULL. This gives full throughput.
- FULL without rsp_ready: all req_ready are 0. The slot contents and last_grant are frozen.
- last_grant changes only on an accept. Idle cycles and stalled cycles do not rotate priority.
- A requester's operands are sampled only in its accept cycle. Requesters hold req_valid and operands until accepted; behaviour is undefined if they drop early.
- rsp_* outputs are stable while rsp_valid && !rsp_ready.

## Timing

- Latency: accept at edge t, rsp_valid high after edge t (visible in cycle t+1).
- Throughput: one operation per cycle when rsp_ready is held high.
- Reset values, asserted synchronously at the next clk edge while rst = 1:
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_cout = 0, rsp_ovf = 0.
  - State EMPTY.
  - last_grant = N_REQ−1, so requester 0 has highest priority first.
- While rst = 1, req_ready = 0.
- Reset mid-operation: a held result is discarded with no rsp handshake and is not replayed.
- The first accept is possible in the first cycle after rst deasserts.
- Fairness: a continuously requesting requester is granted within N_REQ accepts.
- All outputs except req_ready are registered.

## Test plan

- Single add, no borrow:
  - Stimulus: requester 2 sends A=0xFFFFFFFF, B=0x00000001, sub=0.
  - Response: one cycle later rsp_valid=1, rsp_id=2, result=0x00000000, cout=1, ovf=0.
- Subtract with borrow, then signed overflow:
  - Stimulus 1: requester 0 sends A=5, B=7, sub=1. Response: result=0xFFFFFFFE, cout=0, ovf=0.
  - Stimulus 2: A=0x7FFFFFFF, B=1, sub=0. Response: result=0x80000000, cout=0, ovf=1.
  - Stimulus 3: A=0x80000000, B=1, sub=1. Response: result=0x7FFFFFFF, ovf=1.
- Round-robin fairness:
  - Stimulus: after reset, all 4 requesters hold req_valid with rsp_ready=1.
  - Response: grant order is 0,1,2,3,0,1…, one accept per cycle.
  - Stimulus: requester 1 drops after its grant.
  - Response: order continues 2,3,0,2,3,0….
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles while 0 and 3 request.
  - Response: first result stays stable; all req_ready=0; last_grant unchanged.
  - Stimulus: raise rsp_ready.
  - Response: the held result drains and the next accept happens in the same cycle.
- Simultaneous drain and accept:
  - Stimulus: FULL with rsp_ready=1 and requester 1 valid.
  - Response: rsp_id changes to 1 on the next edge with no rsp_valid gap.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while FULL and stalled.
  - Response: rsp_valid=0 and all rsp_* outputs = 0 after the edge.
  - Response: the next grant goes to requester 0 when all are requesting.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter in front of one shared add/subtract carry chain.
// The granted operation's result is captured in a one-entry valid/ready output slot.
module addsub_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 32,
    parameter int IDW   = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    input  logic [N_REQ-1:0]     req_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_result,
    output logic                 rsp_cout,
    output logic                 rsp_ovf
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic             state;
    logic [IDW-1:0]   last_grant;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   gidx;
    logic             found;
    logic [IDW-1:0]   sel;
    logic             can_accept;
    logic             accept;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             op_sub;
    logic [W-1:0]     bx;
    logic [W:0]       sum;
    logic             ovf;

    // Search starts one past the last winner and wraps, so every requester
    // is reached within N_REQ accepts.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sel = IDW'((int'(last_grant) + k) % N_REQ);
            if (!found && req_valid[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                gidx       = sel;
            end
        end
    end

    assign can_accept = !rst && ((state == ST_EMPTY) || rsp_ready);
    assign req_ready  = can_accept ? grant : '0;
    assign accept     = |(req_valid & req_ready);

    always_comb begin
        op_a   = '0;
        op_b   = '0;
        op_sub = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                op_a   = req_a[i*W +: W];
                op_b   = req_b[i*W +: W];
                op_sub = req_sub[i];
            end
        end
    end

    // Subtraction is A + ~B + 1: invert B and feed sub as carry-in.
    assign bx  = op_sub ? ~op_b : op_b;
    assign sum = {1'b0, op_a} + {1'b0, bx} + {{W{1'b0}}, op_sub};
    assign ovf = (op_a[W-1] == bx[W-1]) && (sum[W-1] != op_a[W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            last_grant <= IDW'(N_REQ - 1);
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else if (accept) begin
            state      <= ST_FULL;
            last_grant <= gidx;
            rsp_id     <= gidx;
            rsp_result <= sum[W-1:0];
            rsp_cout   <= sum[W];
            rsp_ovf    <= ovf;
        end else if (state == ST_FULL && rsp_ready) begin
            state <= ST_EMPTY;
        end
    end

    assign rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: arithmetic corners, round-robin order,
// backpressure, drain-with-accept and mid-operation reset.
module tb_addsub_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N-1:0]    req_sub;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [W-1:0]    rsp_result;
    logic            rsp_cout;
    logic            rsp_ovf;

    int checks = 0;
    int errors = 0;

    addsub_arbiter #(.N_REQ(N), .W(W), .IDW(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_sub[i]      = s;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                           input logic [W-1:0] r, input logic c, input logic o);
        chk({tag, ".valid"},  64'(rsp_valid),  64'(v));
        chk({tag, ".id"},     64'(rsp_id),     64'(id));
        chk({tag, ".result"}, 64'(rsp_result), 64'(r));
        chk({tag, ".cout"},   64'(rsp_cout),   64'(c));
        chk({tag, ".ovf"},    64'(rsp_ovf),    64'(o));
    endtask

    initial begin
        int exp_id;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk_rsp("reset", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        req_valid = 4'hF;
        #1;
        chk("ready_in_reset", 64'(req_ready), 64'h0);
        req_valid = '0;
        rst = 1'b0;

        // Single add with carry out, requester 2
        set_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        req_valid = 4'b0100;
        #1;
        chk("add.ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        chk_rsp("add", 1'b1, 2'd2, 32'h0000_0000, 1'b1, 1'b0);
        tick();
        chk("add.drain", 64'(rsp_valid), 64'h0);

        // Subtract with borrow, then overflows, requester 0 back-to-back
        set_op(0, 32'd5, 32'd7, 1'b1);
        req_valid = 4'b0001;
        #1;
        chk("sub.ready", 64'(req_ready), 64'b0001);
        tick();
        chk_rsp("sub_borrow", 1'b1, 2'd0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        set_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0);
        tick();
        chk_rsp("add_ovf", 1'b1, 2'd0, 32'h8000_0000, 1'b0, 1'b1);
        set_op(0, 32'h8000_0000, 32'h1, 1'b1);
        tick();
        req_valid = '0;
        chk_rsp("sub_ovf", 1'b1, 2'd0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        tick();

        // Round robin from a fresh reset: 0,1,2,3,0,1 then 2,3,0 repeating
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, 32'h100 * (i + 1), 32'(i), 1'b0);
        req_valid = 4'hF;
        for (int n = 0; n < 12; n++) begin
            if (n < 6) exp_id = n % 4;
            else       exp_id = (n % 3 == 0) ? 2 : (n % 3 == 1) ? 3 : 0;
            #1;
            chk($sformatf("rr%0d.ready", n), 64'(req_ready), 64'(1 << exp_id));
            tick();
            if (n == 5) req_valid = 4'b1101;
            chk_rsp($sformatf("rr%0d", n), 1'b1, 2'(exp_id),
                    32'h100 * (exp_id + 1) + 32'(exp_id), 1'b0, 1'b0);
        end

        // Backpressure: slot holds requester 0's result, 0 and 3 request
        req_valid = 4'b1001;
        rsp_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk($sformatf("bp%0d.ready", n), 64'(req_ready), 64'h0);
            tick();
            chk_rsp($sformatf("bp%0d", n), 1'b1, 2'd0, 32'h100, 1'b0, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release.ready", 64'(req_ready), 64'b1000);
        tick();
        chk_rsp("bp_release", 1'b1, 2'd3, 32'h403, 1'b0, 1'b0);

        // Drain and accept in the same cycle
        req_valid = 4'b0010;
        #1;
        chk("ovr.ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        chk_rsp("ovr", 1'b1, 2'd1, 32'h201, 1'b0, 1'b0);

        // Reset while full and stalled
        rsp_ready = 1'b0;
        tick();
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("midrst.ready", 64'(req_ready), 64'h0);
        tick();
        rst = 1'b0;
        chk_rsp("midrst", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        #1;
        chk("postrst.ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        chk_rsp("postrst", 1'b1, 2'd0, 32'h100, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
